// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_shift_add_multiplier
// Brief    : Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH product.
//            One partial product per cycle, signed or unsigned per operation,
//            valid/ready handshake on the operand and result sides.
// Revision : 1.0 - initial release
// ============================================================================
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int              CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_mcand;
    // Upper half accumulates partial sums; lower half starts as the multiplier
    // magnitude and is consumed LSB-first as product bits shift in from above.
    logic [2*WIDTH-1:0]     r_acc;
    logic [CW-1:0]          r_count;
    logic                   r_neg;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [2*WIDTH-1:0]     r_product;

    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_acc_next;
    logic [2*WIDTH-1:0]     w_prod_final;

    // Operand magnitudes, one add-and-shift step, and final sign restoration.
    // The most negative operand's magnitude is representable as unsigned WIDTH.
    always_comb begin
        w_a_mag      = (is_signed && a[WIDTH-1]) ? -a : a;
        w_b_mag      = (is_signed && b[WIDTH-1]) ? -b : b;
        w_sum        = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
        w_acc_next   = {w_sum, r_acc[WIDTH-1:1]};
        w_prod_final = r_neg ? -w_acc_next : w_acc_next;
    end

    // Control FSM and datapath registers; all handshake outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_count     <= '0;
            r_neg       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_product   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_mcand    <= w_a_mag;
                        r_acc      <= {{WIDTH{1'b0}}, w_b_mag};
                        r_neg      <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_count    <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + CW'(1);
                    if (r_count == C_LAST) begin
                        r_product   <= w_prod_final;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Result held until taken; no new operation overlaps it.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_shift_add_multiplier
// Brief    : Self-checking bench for seq_shift_add_multiplier (WIDTH=8):
//            directed corner cases, reset abort, stalls and random operations
//            against a plain-arithmetic reference product.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_shift_add_multiplier;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           is_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;

    int n_tests;
    int n_fail;

    seq_shift_add_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact product by ordinary integer arithmetic.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x,
                                               input logic [W-1:0] y,
                                               input logic s);
        longint xi, yi;
        longint p;
        if (s) begin
            xi = longint'($signed(x));
            yi = longint'($signed(y));
        end else begin
            xi = longint'(x);
            yi = longint'(y);
        end
        p = xi * yi;
        return p[2*W-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full operation, entered and left at posedge+1 with the DUT idle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic ts, input int stall, input bit poke);
        logic [2*W-1:0] exp;
        int lat;
        exp = ref_mul(ta, tb_, ts);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a = ta; b = tb_; is_signed = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble operands after accept: must not affect the result.
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); is_signed = 1'($urandom);
        check("in_ready_drop", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(W));
        check("product", 32'(product), 32'(exp));
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                in_valid = 1'b1;
                a = W'($urandom); b = W'($urandom);
            end
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_product", 32'(product), 32'(exp));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_clear", 32'(out_valid), 32'd0);
        check("ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        out_ready = 1'b0;

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases, some with long stalls and ignored requests.
        run_op(8'hFF, 8'hFF, 1'b0, 2, 1'b0);
        check("dir_255x255", 32'(product), 32'h0000_FE01);
        run_op(8'h80, 8'h80, 1'b1, 5, 1'b1);
        check("dir_m128sq", 32'(product), 32'h0000_4000);
        run_op(8'hFF, 8'h7F, 1'b1, 0, 1'b0);
        check("dir_m1x127", 32'(product), 32'h0000_FF81);
        run_op(8'h00, 8'hFB, 1'b1, 1, 1'b0);
        check("dir_0xm5", 32'(product), 32'h0000_0000);
        run_op(8'hFF, 8'h02, 1'b0, 0, 1'b0);
        check("dir_ff02_u", 32'(product), 32'h0000_01FE);
        run_op(8'hFF, 8'h02, 1'b1, 5, 1'b1);
        check("dir_ff02_s", 32'(product), 32'h0000_FFFE);

        // Abort mid-calculation with reset after three iterations.
        a = 8'h37; b = 8'h59; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_no_out", 32'(out_valid), 32'd0);
        run_op(8'h37, 8'h59, 1'b0, 0, 1'b0);

        // Random operations with random result-side back-pressure.
        for (int k = 0; k < 200; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
